pipe_reg_chain: RTL

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage.sv | 44 ++++
 rtl/pipe_reg_chain.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants, the stage record type and the saturating counter helper
// used by the pipe_reg_chain slice.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          PERF_CNT_W = 16;
    localparam int          REC_W      = 32;

    typedef struct packed {
        logic             valid;
        logic [REC_W-1:0] pc;
        logic [REC_W-1:0] instr;
    } stage_rec_t;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of pipe_reg_chain: valid bit plus pc/instr payload,
// with its own load condition derived from the downstream stage.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_INSTR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_pc,
    input  logic [WIDTH-1:0] prev_instr,
    input  logic             next_load,
    output logic             load,
    output logic             valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr
);

    // An empty stage always accepts, so bubbles collapse under backpressure.
    assign load = !stall && !flush && (!valid || next_load);

    // NOTE: non-blocking assignments so every stage samples its predecessor's
    // pre-edge value and the chain shifts by exactly one position per edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= BUBBLE;
        end else if (load) begin
            valid <= prev_valid;
            pc    <= prev_pc;
            instr <= prev_instr;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain for pc/instr with stall and flush.
// Optional macro PIPE_REG_CHAIN_PERF_EN adds saturating stall/flush counters.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter int               DEPTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      pc_in,
    input  logic [WIDTH-1:0]      instr_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      instr_out
`ifdef PIPE_REG_CHAIN_PERF_EN
   ,output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             load;
        logic             next_load;
        logic             prev_valid;
        logic [WIDTH-1:0] prev_pc;
        logic [WIDTH-1:0] prev_instr;
        logic             valid;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;

        if (k == DEPTH - 1) begin : g_last
            assign next_load = out_ready;
        end else begin : g_mid
            assign next_load = g_stage[k+1].load;
        end

        if (k == 0) begin : g_first
            assign prev_valid = in_valid;
            assign prev_pc    = pc_in;
            assign prev_instr = instr_in;
        end else begin : g_follow
            assign prev_valid = g_stage[k-1].valid;
            assign prev_pc    = g_stage[k-1].pc;
            assign prev_instr = g_stage[k-1].instr;
        end

        pipe_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .stall      (stall),
            .flush      (flush),
            .prev_valid (prev_valid),
            .prev_pc    (prev_pc),
            .prev_instr (prev_instr),
            .next_load  (next_load),
            .load       (load),
            .valid      (valid),
            .pc         (pc),
            .instr      (instr)
        );
    end

    assign in_ready  = g_stage[0].load;
    assign out_valid = g_stage[DEPTH-1].valid;
    assign pc_out    = g_stage[DEPTH-1].pc;
    assign instr_out = g_stage[DEPTH-1].instr;

`ifdef PIPE_REG_CHAIN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= sat_inc(stall_cnt);
            if (flush) flush_cnt <= sat_inc(flush_cnt);
        end
    end
`endif

endmodule
